// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer slice.
package tdm_pkg;

  typedef enum logic {
    TDM_IDLE,
    TDM_COLLECT
  } tdm_state_t;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/tdm_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module tdm_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: assembles slot-multiplexed serial bits into
// lane words, flagging mid-frame restarts and stall timeouts.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  input  logic                 d_valid,
  input  logic                 sof,
  output logic [LANES-1:0]     y,
  output logic                 y_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned SLOT_W  = $clog2(LANES + 1);
  localparam int unsigned STALL_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(LANES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  tdm_state_t         r_state;
  logic [SLOT_W-1:0]  r_slot;
  logic [LANES-1:0]   r_asm;
  logic [STALL_W-1:0] r_stall;

  logic               w_restart;
  logic               w_timeout;
  logic               w_err_set;
  logic [LANES-1:0]   w_merged;

  // Assembly word with the current bit placed at the current slot.
  always_comb begin
    w_merged = r_asm;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (r_slot == SLOT_W'(k)) begin
        w_merged[k] = d;
      end
    end
  end

  // Timeout fires on the gap that brings the stall count to TIMEOUT.
  assign w_restart = (r_state == TDM_COLLECT) && d_valid && sof;
  assign w_timeout = TO_EN && (r_state == TDM_COLLECT) && !d_valid &&
                     (r_stall == STALL_MAX - STALL_W'(1));
  assign w_err_set = w_restart || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TDM_IDLE;
      r_slot  <= '0;
      r_asm   <= '0;
      r_stall <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      err     <= w_err_set;
      unique case (r_state)
        TDM_IDLE: begin
          r_stall <= '0;
          if (d_valid && sof) begin
            if (LANES == 1) begin
              y       <= w_merged;
              y_valid <= 1'b1;
            end else begin
              r_asm[0] <= d;
              r_slot   <= SLOT_W'(1);
              r_state  <= TDM_COLLECT;
            end
          end
        end
        TDM_COLLECT: begin
          if (d_valid) begin
            r_stall <= '0;
            if (sof) begin
              r_asm[0] <= d;
              r_slot   <= SLOT_W'(1);
            end else if (r_slot == LAST_SLOT) begin
              y       <= w_merged;
              y_valid <= 1'b1;
              r_slot  <= '0;
              r_state <= TDM_IDLE;
            end else begin
              r_asm  <= w_merged;
              r_slot <= r_slot + SLOT_W'(1);
            end
          end else if (w_timeout) begin
            r_stall <= '0;
            r_slot  <= '0;
            r_state <= TDM_IDLE;
          end else if (r_stall != STALL_MAX) begin
            r_stall <= r_stall + STALL_W'(1);
          end
        end
        default: r_state <= TDM_IDLE;
      endcase
    end
  end

  tdm_sat_cnt #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_err_set),
    .q  (err_cnt)
  );

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: three instances (4/16, 1/0, 5/3) against a frame-level model.
module tb_tdm_demux;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [N];
  logic       d   [N];
  logic       dv  [N];
  logic       sof [N];
  logic [3:0] y0;
  logic       y1;
  logic [4:0] y2;
  logic       yv  [N];
  logic       er  [N];
  logic [7:0] ec  [N];

  tdm_demux #(.LANES(4), .TIMEOUT(16)) u_dut0 (
    .clk(clk), .rst(rst[0]), .d(d[0]), .d_valid(dv[0]), .sof(sof[0]),
    .y(y0), .y_valid(yv[0]), .err(er[0]), .err_cnt(ec[0]));
  tdm_demux #(.LANES(1), .TIMEOUT(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .d(d[1]), .d_valid(dv[1]), .sof(sof[1]),
    .y(y1), .y_valid(yv[1]), .err(er[1]), .err_cnt(ec[1]));
  tdm_demux #(.LANES(5), .TIMEOUT(3)) u_dut2 (
    .clk(clk), .rst(rst[2]), .d(d[2]), .d_valid(dv[2]), .sof(sof[2]),
    .y(y2), .y_valid(yv[2]), .err(er[2]), .err_cnt(ec[2]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: an open frame is the list of bits accepted since its sof.
  bit        inf  [N];
  bit [31:0] fr   [N];
  int        fc   [N];
  int        gaps [N];
  bit [31:0] my   [N];
  bit        myv  [N];
  bit        merr [N];
  int        mcnt [N];
  int        gapleft [N];

  function automatic int lanes_of(int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 5;
  endfunction

  function automatic int to_of(int i);
    return (i == 0) ? 16 : (i == 1) ? 0 : 3;
  endfunction

  function automatic logic [31:0] act_y(int i);
    if (i == 0) return 32'(y0);
    if (i == 1) return 32'(y1);
    return 32'(y2);
  endfunction

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(int i);
    int L = lanes_of(i);
    int T = to_of(i);
    myv[i]  = 1'b0;
    merr[i] = 1'b0;
    if (rst[i]) begin
      inf[i] = 1'b0; fc[i] = 0; gaps[i] = 0; my[i] = '0; mcnt[i] = 0;
      return;
    end
    if (dv[i]) begin
      gaps[i] = 0;
      if (sof[i]) begin
        if (inf[i]) begin
          merr[i] = 1'b1;
          if (mcnt[i] < 255) mcnt[i]++;
        end
        inf[i] = 1'b1; fr[i] = '0; fc[i] = 0;
      end
      if (inf[i]) begin
        fr[i][fc[i]] = d[i];
        fc[i]++;
        if (fc[i] == L) begin
          my[i] = fr[i]; myv[i] = 1'b1; inf[i] = 1'b0;
        end
      end
    end else if (inf[i]) begin
      gaps[i]++;
      if (T != 0 && gaps[i] == T) begin
        merr[i] = 1'b1;
        if (mcnt[i] < 255) mcnt[i]++;
        inf[i] = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        cmp($sformatf("y_dut%0d", i), act_y(i), my[i]);
        cmp($sformatf("y_valid_dut%0d", i), 32'(yv[i]), 32'(myv[i]));
        cmp($sformatf("err_dut%0d", i), 32'(er[i]), 32'(merr[i]));
        cmp($sformatf("err_cnt_dut%0d", i), 32'(ec[i]), 32'(mcnt[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
    @(negedge clk);
  endtask

  task automatic b0(bit s, bit dd, bit v);
    sof[0] = s; d[0] = dd; dv[0] = v;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; d[i] = 1'b0; dv[i] = 1'b0; sof[i] = 1'b0;
      inf[i] = 1'b0; fr[i] = '0; fc[i] = 0; gaps[i] = 0;
      my[i] = '0; myv[i] = 1'b0; merr[i] = 1'b0; mcnt[i] = 0; gapleft[i] = 0;
    end
    chk_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    cmp("reset_y", 32'(y0), 32'h0);
    cmp("reset_err_cnt", 32'(ec[0]), 32'h0);

    // Normal frame
    b0(1, 1, 1); b0(0, 0, 1); b0(0, 1, 1);
    cmp("normal_early_valid", 32'(yv[0]), 32'h0);
    b0(0, 1, 1);
    cmp("normal_y", 32'(y0), 32'hd);
    cmp("normal_valid", 32'(yv[0]), 32'h1);
    b0(0, 0, 0);
    cmp("normal_strobe_len", 32'(yv[0]), 32'h0);

    // Discarded beats in IDLE, then a frame with a 5-cycle gap
    repeat (3) b0(0, 1, 1);
    b0(1, 1, 1); b0(0, 1, 1);
    repeat (5) b0(0, 0, 0);
    cmp("gap_y_held", 32'(y0), 32'hd);
    b0(0, 0, 1); b0(0, 0, 1);
    cmp("gap_y", 32'(y0), 32'h3);
    cmp("gap_err_cnt", 32'(ec[0]), 32'h0);

    // Restart mid-frame
    b0(1, 1, 1); b0(0, 1, 1); b0(1, 0, 1);
    cmp("restart_err", 32'(er[0]), 32'h1);
    cmp("restart_err_cnt", 32'(ec[0]), 32'h1);
    b0(0, 0, 1);
    cmp("restart_err_len", 32'(er[0]), 32'h0);
    b0(0, 0, 1); b0(0, 1, 1);
    cmp("restart_y", 32'(y0), 32'h8);

    // Timeout after 16 gap cycles
    b0(1, 1, 1);
    repeat (15) b0(0, 0, 0);
    cmp("timeout_early", 32'(er[0]), 32'h0);
    b0(0, 0, 0);
    cmp("timeout_err", 32'(er[0]), 32'h1);
    cmp("timeout_err_cnt", 32'(ec[0]), 32'h2);
    b0(0, 1, 1);
    cmp("timeout_ignored", 32'(yv[0]), 32'h0);
    b0(1, 1, 1); b0(0, 0, 1); b0(0, 1, 1); b0(0, 0, 1);
    cmp("timeout_next_y", 32'(y0), 32'h5);

    // Saturation, then reset mid-frame
    b0(1, 0, 1);
    repeat (260) b0(1, 0, 1);
    cmp("sat_err_cnt", 32'(ec[0]), 32'hff);
    cmp("sat_err", 32'(er[0]), 32'h1);
    b0(0, 1, 1);
    rst[0] = 1'b1;
    b0(0, 1, 1);
    rst[0] = 1'b0;
    cmp("rst_y", 32'(y0), 32'h0);
    cmp("rst_err_cnt", 32'(ec[0]), 32'h0);
    cmp("rst_valid", 32'(yv[0]), 32'h0);
    b0(1, 0, 1); b0(0, 1, 1); b0(0, 1, 1); b0(0, 0, 1);
    cmp("rst_fresh_y", 32'(y0), 32'h6);
    dv[0] = 1'b0;

    // Back-to-back single-lane frames
    for (int k = 0; k < 8; k++) begin
      sof[1] = 1'b1; dv[1] = 1'b1; d[1] = k[0];
      tick();
      cmp("l1_valid", 32'(yv[1]), 32'h1);
      cmp("l1_y", 32'(y1), 32'(k[0]));
    end

    // Randomized traffic on all instances
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(0, 299) == 0);
        if (gapleft[i] > 0) begin
          gapleft[i]--;
          dv[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          gapleft[i] = $urandom_range(1, 20);
          dv[i] = 1'b0;
        end else begin
          dv[i] = ($urandom_range(0, 3) != 0);
        end
        sof[i] = ($urandom_range(0, 4) == 0);
        d[i]   = $urandom_range(0, 1);
      end
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
